// File: rtl/axis_frame_tx.sv
// -----------------------------------------------------------------------------
// axis_frame_tx
//
// AXI-Stream frame transmitter. A DD x DW sample memory is loaded through a
// simple write port. A start pulse plays the first frame_len words out as a
// frame, with m_tlast on the final word. This repeats for num_frames
// back-to-back frames, with full backpressure support.
//
// Ports
//   clk             clock
//   rst             synchronous, active-high reset
//   i_ld_we         memory write enable (ignored while busy)
//   i_ld_addr       memory write address
//   i_ld_data       memory write data
//   i_start         run request, sampled only while idle
//   i_frame_len     words per frame; 0 or >DD clamps to DD
//   i_num_frames    frames per run; 0 is treated as 1
//   o_m_tdata       stream data
//   o_m_tvalid      stream valid
//   o_m_tlast       last word of each frame
//   i_m_tready      downstream ready
//   o_busy          run in progress
//   o_done          one-cycle pulse after the final tlast handshake
//
// Datapath: the memory read register is the primary output slot. A one-entry
// skid slot holds the older word when a read lands while the stream is
// stalled. The skid slot, when occupied, is always the head of the stream.
// DD must equal 2**AW.
// -----------------------------------------------------------------------------
module axis_frame_tx #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16,
  parameter int unsigned DD = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ld_we,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data,
  input  logic          i_start,
  input  logic [AW:0]   i_frame_len,
  input  logic [7:0]    i_num_frames,
  output logic [DW-1:0] o_m_tdata,
  output logic          o_m_tvalid,
  output logic          o_m_tlast,
  input  logic          i_m_tready,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [AW:0] LenMax = (AW + 1)'(DD);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_t;

  state_t        r_state;
  logic [AW:0]   r_len;
  logic [AW:0]   r_word_cnt;
  logic [7:0]    r_nf;
  logic [7:0]    r_frame_cnt;
  logic          r_busy;
  logic          r_done;

  logic [DW-1:0] r_mem [DD];

  // Read register (primary slot) and skid slot.
  logic [DW-1:0] r_rd_data;
  logic          r_rd_vld;
  logic          r_rd_last;
  logic [DW-1:0] r_skid_data;
  logic          r_skid_vld;
  logic          r_skid_last;

  logic [AW:0]   w_len_clamp;
  logic [7:0]    w_nf_clamp;
  logic          w_valid;
  logic          w_hs;
  logic          w_room;
  logic          w_issue;
  logic          w_last_word;
  logic          w_last_frame;
  logic          w_final_hs;
  logic          w_rd_consumed;
  logic          w_rd_to_skid;

  always_comb begin
    w_len_clamp = i_frame_len;
    if (i_frame_len == '0 || i_frame_len > LenMax) begin
      w_len_clamp = LenMax;
    end
    w_nf_clamp = (i_num_frames == 8'd0) ? 8'd1 : i_num_frames;
  end

  assign w_valid = r_rd_vld | r_skid_vld;
  assign w_hs    = w_valid & i_m_tready;

  // Only refuse a read when both slots are full and nothing leaves this cycle.
  assign w_room  = !(r_rd_vld && r_skid_vld && !w_hs);
  assign w_issue = (r_state == StRun) && w_room;

  assign w_last_word  = (r_word_cnt == r_len - 1'b1);
  assign w_last_frame = (r_frame_cnt == r_nf - 8'd1);

  // In drain no further reads are issued, so the handshake that empties the
  // pipeline is the final word of the final frame.
  assign w_final_hs = w_hs && (r_rd_vld ^ r_skid_vld);

  // The read register is the head only when the skid slot is empty.
  assign w_rd_consumed = w_hs && !r_skid_vld;
  // A new read landing on an unconsumed read register pushes it to the skid.
  assign w_rd_to_skid  = w_issue && r_rd_vld && !w_rd_consumed;

  // Write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_ld_we && !r_busy) begin
      r_mem[i_ld_addr] <= i_ld_data;
    end
  end

  // Control FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_nf        <= '0;
      r_word_cnt  <= '0;
      r_frame_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_len       <= w_len_clamp;
            r_nf        <= w_nf_clamp;
            r_word_cnt  <= '0;
            r_frame_cnt <= '0;
            r_busy      <= 1'b1;
            r_state     <= StRun;
          end
        end
        StRun: begin
          if (w_issue) begin
            if (w_last_word) begin
              r_word_cnt  <= '0;
              r_frame_cnt <= r_frame_cnt + 8'd1;
              if (w_last_frame) begin
                r_state <= StDrain;
              end
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end
        StDrain: begin
          if (w_final_hs) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Output slots. The read address is the word counter, since len <= DD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data   <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_skid_data <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_last <= 1'b0;
    end else begin
      if (w_rd_to_skid) begin
        r_skid_data <= r_rd_data;
        r_skid_last <= r_rd_last;
        r_skid_vld  <= 1'b1;
      end else if (w_hs && r_skid_vld) begin
        r_skid_vld  <= 1'b0;
      end

      if (w_issue) begin
        r_rd_data <= r_mem[r_word_cnt[AW-1:0]];
        r_rd_last <= w_last_word;
        r_rd_vld  <= 1'b1;
      end else if (w_rd_consumed) begin
        r_rd_vld  <= 1'b0;
      end
    end
  end

  assign o_m_tvalid = w_valid;
  assign o_m_tdata  = r_skid_vld ? r_skid_data : r_rd_data;
  assign o_m_tlast  = r_skid_vld ? r_skid_last : (r_rd_vld & r_rd_last);
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_axis_frame_tx.sv
module tb_axis_frame_tx;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int DD = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_ld_we;
  logic [AW-1:0] i_ld_addr;
  logic [DW-1:0] i_ld_data;
  logic          i_start;
  logic [AW:0]   i_frame_len;
  logic [7:0]    i_num_frames;
  logic [DW-1:0] o_m_tdata;
  logic          o_m_tvalid;
  logic          o_m_tlast;
  logic          i_m_tready;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  axis_frame_tx #(
    .AW(AW),
    .DW(DW),
    .DD(DD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ld_we     (i_ld_we),
    .i_ld_addr   (i_ld_addr),
    .i_ld_data   (i_ld_data),
    .i_start     (i_start),
    .i_frame_len (i_frame_len),
    .i_num_frames(i_num_frames),
    .o_m_tdata   (o_m_tdata),
    .o_m_tvalid  (o_m_tvalid),
    .o_m_tlast   (o_m_tlast),
    .i_m_tready  (i_m_tready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Shadow of what the sample memory should hold.
  logic [DW-1:0] ref_mem [DD];

  typedef struct {
    int len;
    int nf;
    int exp_words;
    int exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input int addr, input logic [DW-1:0] data);
    i_ld_we   = 1'b1;
    i_ld_addr = addr[AW-1:0];
    i_ld_data = data;
    @(posedge clk);
    #1;
    i_ld_we = 1'b0;
    ref_mem[addr] = data;
  endtask

  // Starts a run and checks every handshake against the expected word list.
  // inj_cyc: cycle at which a start/ld_we pulse is injected mid-run (-1 none).
  // rst_hs: handshake index at which rst is asserted, aborting the run (-1 none).
  // exp_done: exact cycle of done when known (-1 not checked).
  task automatic run(input int len_in, input int nf_in, input int pct, input int inj_cyc,
                     input int rst_hs, input int exp_done, output int nwords);
    int            L, F, total, idx, cyc, last_hs, budget;
    logic [DW-1:0] exp_d [$];
    logic          exp_l [$];
    logic          prev_stall, prev_l, rdy, fin;
    logic [DW-1:0] prev_d;

    L = (len_in == 0 || len_in > DD) ? DD : len_in;
    F = (nf_in == 0) ? 1 : nf_in;
    for (int f = 0; f < F; f++) begin
      for (int w = 0; w < L; w++) begin
        exp_d.push_back(ref_mem[w]);
        exp_l.push_back(w == L - 1);
      end
    end
    total  = L * F;
    budget = total * 30 + 50;

    i_frame_len  = len_in[AW:0];
    i_num_frames = nf_in[7:0];
    i_start      = 1'b1;
    @(posedge clk);
    #1;
    i_start      = 1'b0;
    i_frame_len  = '0;
    i_num_frames = '0;

    cyc = 1; idx = 0; last_hs = -10; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    fin = 1'b0; nwords = 0;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);

    while (!fin && cyc < budget) begin
      rdy = ($urandom_range(99) < pct);
      i_m_tready = rdy;
      if (cyc == inj_cyc) begin
        i_start      = 1'b1;
        i_frame_len  = 13'd3;
        i_num_frames = 8'd7;
        i_ld_we      = 1'b1;
        i_ld_addr    = '0;
        i_ld_data    = 16'hFFFF;
      end
      if (prev_stall) begin
        check("hold_valid", {31'd0, o_m_tvalid}, 32'd1);
        check("hold_data", {16'd0, o_m_tdata}, {16'd0, prev_d});
        check("hold_last", {31'd0, o_m_tlast}, {31'd0, prev_l});
      end
      if (o_done) begin
        fin = 1'b1;
        check("done_after_last_hs", cyc, last_hs + 1);
        check("done_all_words", idx, total);
        check("busy_at_done", {31'd0, o_busy}, 32'd0);
        if (exp_done >= 0) check("done_cycle", cyc, exp_done);
      end else begin
        check("busy_in_run", {31'd0, o_busy}, 32'd1);
      end
      if (o_m_tvalid && rdy) begin
        if (idx < total) begin
          check($sformatf("data[%0d]", idx), {16'd0, o_m_tdata}, {16'd0, exp_d[idx]});
          check($sformatf("last[%0d]", idx), {31'd0, o_m_tlast}, {31'd0, exp_l[idx]});
        end else begin
          check("extra_word", idx, total - 1);
        end
        if (idx == rst_hs) rst = 1'b1;
        last_hs = cyc;
        idx++;
      end
      prev_stall = o_m_tvalid && !rdy;
      prev_d     = o_m_tdata;
      prev_l     = o_m_tlast;
      @(posedge clk);
      #1;
      i_start      = 1'b0;
      i_ld_we      = 1'b0;
      i_frame_len  = '0;
      i_num_frames = '0;
      if (rst) begin
        rst = 1'b0;
        check("rst_tvalid", {31'd0, o_m_tvalid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        nwords = idx;
        return;
      end
      cyc++;
    end
    if (!fin) check("done_timeout", 32'd0, 32'd1);
    nwords = idx;

    // Nothing further may happen: no second done, no restarted run.
    for (int k = 0; k < 3; k++) begin
      check("idle_done", {31'd0, o_done}, 32'd0);
      check("idle_busy", {31'd0, o_busy}, 32'd0);
      check("idle_valid", {31'd0, o_m_tvalid}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len, nf, pct;

    vecs[0] = '{len: 4,    nf: 2,   exp_words: 8,    exp_done: 10};
    vecs[1] = '{len: 3,    nf: 1,   exp_words: 3,    exp_done: 5};
    vecs[2] = '{len: 1,    nf: 3,   exp_words: 3,    exp_done: 5};
    vecs[3] = '{len: 0,    nf: 1,   exp_words: 4096, exp_done: 4098};
    vecs[4] = '{len: 5000, nf: 1,   exp_words: 4096, exp_done: 4098};
    vecs[5] = '{len: 2,    nf: 255, exp_words: 510,  exp_done: 512};

    rst = 1'b1; i_ld_we = 1'b0; i_ld_addr = '0; i_ld_data = '0; i_start = 1'b0;
    i_frame_len = '0; i_num_frames = '0; i_m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", {31'd0, o_m_tvalid}, 32'd0);
    check("reset_tlast", {31'd0, o_m_tlast}, 32'd0);
    check("reset_tdata", {16'd0, o_m_tdata}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_done", {31'd0, o_done}, 32'd0);
    rst = 1'b0;

    // Full-memory ramp.
    for (int i = 0; i < DD; i++) load(i, 16'(i));

    // Table-driven runs with the stream always ready.
    for (int v = 0; v < 6; v++) begin
      run(vecs[v].len, vecs[v].nf, 100, -1, -1, vecs[v].exp_done, n);
      check($sformatf("vec%0d_words", v), n, vecs[v].exp_words);
    end

    // Random backpressure, 3 frames of 5.
    run(5, 3, 50, -1, -1, -1, n);
    check("bp_words", n, 15);

    // Single word, num_frames=0.
    load(0, 16'hA5A5);
    run(1, 0, 100, -1, -1, 3, n);
    check("single_words", n, 1);
    load(0, 16'h0000);

    // start and ld_we pulsed mid-run are ignored.
    run(8, 2, 100, 4, -1, 18, n);
    check("inject_words", n, 16);
    run(1, 1, 100, -1, -1, 3, n);
    check("inject_mem_kept", n, 1);

    // Reset at the third handshake, then replay from word 0.
    run(8, 1, 100, -1, 2, -1, n);
    check("rst_abort_words", n, 3);
    run(8, 1, 100, -1, -1, 10, n);
    check("rst_replay_words", n, 8);

    // Random contents, lengths, frame counts and backpressure.
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 6; k++) load($urandom_range(0, 23), 16'($urandom()));
      len = $urandom_range(1, 24);
      nf  = $urandom_range(0, 4);
      pct = $urandom_range(25, 100);
      run(len, nf, pct, -1, -1, -1, n);
      check($sformatf("rand%0d_words", it), n, ((nf == 0) ? 1 : nf) * len);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_tx.md
# axis_frame_tx

AXI-Stream frame transmitter: the source end of the team's buffered AXI-Stream frame path. Holds a DD-word sample memory loaded through a simple write port. On a start pulse it plays the first frame_len words out as a frame with m_tlast on the final word, repeating for num_frames back-to-back frames. It drives test and replay traffic into downstream axis_fifo-style frame buffers, with full AXI-Stream backpressure support.

## Interface
- AW, 12, memory address width.
- DW, 16, data width.
- DD, 4096, memory depth; must equal 2^AW.
- clk  in  1  clock (already decided).
- rst  in  1  reset: synchronous, active-high (already decided).
- ld_we  in  1  memory write enable; ignored while busy=1.
- ld_addr  in  AW  memory write address.
- ld_data  in  DW  memory write data.
- start  in  1  one-cycle request; sampled only while busy=0.
- frame_len  in  AW+1  words per frame, latched at start; 0 or >DD clamps to DD.
- num_frames  in  8  frames per run, latched at start; 0 treated as 1.
- m_tdata  out  DW  stream data.
- m_tvalid  out  1  stream valid.
- m_tlast  out  1  high on the last word of each frame.
- m_tready  in  1  downstream ready.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse after the final m_tlast handshake.

## Operation
- Memory: DD x DW, 1-cycle synchronous read; write port is independent. Contents are not cleared by rst.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start=1. Latch clamped frame_len and num_frames, set rd_addr=0, word_cnt=0, frame_cnt=0, busy=1.
  - RUN: issue one read per cycle whenever the output register plus skid slot can accept the result.
    - Each issued read carries a last flag = (word_cnt == len-1).
    - On the last word of a frame, reset rd_addr and word_cnt to 0 and increment frame_cnt.
    - After the last word of the last frame is issued, go to DRAIN.
  - DRAIN: wait until the word with last flag of the final frame handshakes, then go to IDLE.
    - done=1 for one cycle in the following cycle; busy=0 in that same cycle.
- Output path: output register plus one-entry skid buffer. This absorbs the read in flight when m_tready drops, so no read is dropped or duplicated.
- m_tlast is valid only with m_tvalid=1. There is no gap between frames: the word after a tlast handshake is word 0 of the next frame.
- start while busy=1: ignored; latched values are unaffected.
- ld_we while busy=1: ignored; memory is unchanged.
- Counters: word_cnt is AW+1 bits. Address wrap is never needed because len<=DD.

## Timing
- Reset values:
  - m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0.
  - FSM=IDLE, skid buffer empty, all counters 0.
- start sampled high at cycle 0:
  - busy=1 from cycle 1.
  - First read issued in cycle 1.
  - m_tvalid=1 with word 0 from cycle 2.
- Throughput is 1 word/cycle with m_tready held high. A run of F frames of L words has its final handshake at cycle 1+F*L, done=1 at cycle 2+F*L, and busy falls at cycle 2+F*L.
- AXI-Stream rules:
  - m_tvalid never depends combinationally on m_tready.
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast are held stable.
  - m_tvalid does not drop until the handshake occurs.
- Reset mid-run: in the cycle after rst, all outputs take their reset values and the stream is abandoned without tlast. Memory contents are retained.
- rst has priority over start in the same cycle.

## Test plan
- Load memory[i]=i for i=0..7. Set frame_len=4, num_frames=2, start at cycle 0, m_tready=1.
  - Required: m_tdata 0,1,2,3,0,1,2,3 on cycles 2-9.
  - Required: m_tlast at cycles 5 and 9; done at cycle 10; busy=1 on cycles 1-9.
- Same load, frame_len=5, num_frames=3, m_tready random ~50%.
  - Required: exactly 15 handshakes in the order 0-4 repeated, tlast on every 5th handshake.
  - Required: m_tdata/m_tlast stable whenever m_tvalid=1 and m_tready=0.
  - Required: done exactly once.
- Load memory[0]=0xA5A5. Set frame_len=1, num_frames=0.
  - Required: a single word 0xA5A5 with m_tlast=1, then done.
- Set frame_len=0 with a full-memory ramp loaded.
  - Required: 4096 words 0..4095, tlast only on 4095.
- Pulse start and ld_we (addr 0, data 0xFFFF) mid-run.
  - Required: the run continues unchanged, memory[0] is unchanged, and no second run starts.
- Assert rst at the third handshake of a frame_len=8 run.
  - Required: the next cycle shows m_tvalid=0, busy=0, done=0.
  - Required: a new start replays from word 0 with the original memory contents.
